adf4158_prog: RTL and testbench
===============================

Name: adf4158_prog

Overview:
Parametrised ADF4158 programming engine, successor to the fixed-sequence adf4158 driver.
- Holds an internal, host-writable bank of NREG registers of REG_W bits each.
- On start_i, serialises the bank to the PLL over CLK/DATA/LE, highest index first (R7..R0), at a configurable serial clock rate.
- Gates the ramp trigger (TXDATA) until at least one full programming pass has completed.
- Sits between the FPGA control logic and the ADF4158 pins.

Parameters:
NREG, 8, number of registers in the bank and written per pass
REG_W, 32, bits per register, shifted MSB first
CLK_DIV, 2, clk_i cycles per serial clock half-period (>=1)
LE_W, 4, clk_i cycles le_o held high between registers (>=1)
CE_DELAY, 16, clk_i cycles from ce_o rising to first LOAD on the first pass only

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
cfg_we_i  in  1  register bank write strobe
cfg_addr_i  in  $clog2(NREG)  bank write index
cfg_data_i  in  REG_W  bank write data
start_i  in  1  single-cycle request to program the whole bank
ramp_i  in  1  ramp trigger request from the sweep controller
busy_o  out  1  pass in progress
done_o  out  1  one-cycle pulse when a pass completes
configured_o  out  1  sticky; at least one pass completed
ce_o  out  1  PLL chip enable
le_o  out  1  PLL load enable
clk_o  out  1  PLL serial clock
data_o  out  1  PLL serial data
txdata_o  out  1  PLL TXDATA ramp trigger

Behaviour:
- Reset values (async on rst_n_i low):
  - busy_o=0, done_o=0, configured_o=0, ce_o=0, clk_o=0, data_o=0, txdata_o=0.
  - le_o=1.
  - All bank entries = 0.
  - State = IDLE.
- Reset mid-pass aborts immediately to these values; no partial LE pulse is issued.
- Bank writes:
  - cfg_we_i writes cfg_data_i to entry cfg_addr_i on the next edge when busy_o=0.
  - Writes while busy_o=1 are ignored.
  - cfg_addr_i >= NREG is ignored.
- start_i:
  - Accepted only in IDLE; ignored when busy_o=1.
  - A cfg_we_i in the same cycle as an accepted start_i is applied first, so the pass uses the new value.
- States and transitions:
  - IDLE -> PWRUP on start_i when ce_o=0. Sets ce_o=1 and busy_o=1.
  - IDLE -> LOAD on start_i when ce_o=1. Sets busy_o=1.
  - PWRUP: counts CE_DELAY cycles -> LOAD.
  - LOAD (1 cycle): idx starts at NREG-1. Copies bank[idx] to the shift register, le_o=0, data_o=MSB, clk_o=0 -> SHIFT.
  - SHIFT: each bit spans 2*CLK_DIV cycles. clk_o is low for the first CLK_DIV cycles and high for the second, so data is stable at the rising edge. At the end of a bit's high phase, clk_o=0 and data_o advances to the next bit. After REG_W bits, clk_o=0, data_o=0, le_o=1 -> LATCH.
  - LATCH: holds le_o=1 for LE_W cycles. If idx>0: idx-1 -> LOAD. Else -> DONE.
  - DONE (1 cycle): done_o=1, busy_o=0, configured_o=1 -> IDLE.
- Per-register time: 1 + 2*CLK_DIV*REG_W + LE_W cycles.
- Pass length: NREG times the per-register time, plus CE_DELAY on the first pass, plus 1 for DONE.
- ce_o stays 1 after the first pass; only reset clears it.
- txdata_o is a one-cycle register of (ramp_i & configured_o & ~busy_o). It is forced 0 during any pass and before the first pass.
- Counters are sized by $clog2 of their maximum values. No wrap occurs within a pass.

Decomposition:
- Package adf4158_pkg holds:
  - The state enum (IDLE, PWRUP, LOAD, SHIFT, LATCH, DONE).
  - ADF4158_NREG=8 and ADF4158_REG_W=32 constants.
- Sub-module adf4158_ser: the bit timer plus shift register. Inputs: load pulse and word. Outputs: clk_o, data_o and a word_done pulse. Parameters: REG_W, CLK_DIV.
- The top level owns the bank, the FSM, CE/LE and TXDATA gating.

Test Plan:
1. Reset, then write bank[k]=32'h0000_0000+k for k=0..7, then pulse start_i (CLK_DIV=2, LE_W=4, CE_DELAY=16) -> ce_o rises next cycle. First clk_o rising edge occurs 16+1+2 cycles later. Words are captured on clk_o rising edges in order 7..0. Eight le_o high pulses of 4 cycles each. done_o occurs exactly 16+8*133+1 cycles after start.
2. Second start_i after completion -> no PWRUP delay, 8*133+1 cycles to done_o, ce_o remains 1 throughout.
3. ramp_i=1 before the first pass -> txdata_o=0. ramp_i=1 during a pass -> txdata_o=0. After done_o, txdata_o=1 one cycle after ramp_i=1.
4. cfg_we_i to bank[3]=32'hDEAD_BEEF, and start_i pulsed again, while busy -> the captured word for R3 is unchanged and the pass length is unchanged. After done, the write is still not applied.
5. Assert rst_n_i low mid-SHIFT of R5 -> all outputs return to reset values asynchronously and the bank is cleared. A subsequent start_i re-enters PWRUP.
6. cfg_we_i to bank[0]=32'h0000_0007 in the same cycle as start_i -> the last word shifted is 32'h0000_0007.

Source files
------------

// File: rtl/adf4158_pkg.sv
// Shared types and constants for the ADF4158 programming engine.
package adf4158_pkg;

  localparam int unsigned ADF4158_NREG  = 8;
  localparam int unsigned ADF4158_REG_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    LOAD,
    SHIFT,
    LATCH,
    DONE
  } state_e;

  // Counter/index width that stays legal when the range collapses to one value.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/adf4158_prog_if.sv
// Host-side control/status bundle of the ADF4158 programming engine.
interface adf4158_prog_if
  import adf4158_pkg::*;
#(
  parameter int unsigned NREG  = ADF4158_NREG,
  parameter int unsigned REG_W = ADF4158_REG_W
);

  localparam int unsigned AW = clog2_min1(NREG);

  logic             cfg_we_i;
  logic [AW-1:0]    cfg_addr_i;
  logic [REG_W-1:0] cfg_data_i;
  logic             start_i;
  logic             ramp_i;
  logic             busy_o;
  logic             done_o;
  logic             configured_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_data_i, start_i, ramp_i,
    input  busy_o, done_o, configured_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_data_i, start_i, ramp_i,
    output busy_o, done_o, configured_o
  );

endinterface

// File: rtl/adf4158_ser.sv
// Bit timer and MSB-first shift register for one PLL register word.
// word_done is raised during the final cycle of the word so the caller can
// raise LE on the same edge that returns clk_o/data_o low.
module adf4158_ser
  import adf4158_pkg::*;
#(
  parameter int unsigned REG_W   = ADF4158_REG_W,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic [REG_W-1:0] word,
  output logic             clk_o,
  output logic             data_o,
  output logic             word_done
);

  localparam int unsigned PH_W  = clog2_min1(2 * CLK_DIV);
  localparam int unsigned BIT_W = clog2_min1(REG_W);

  logic [REG_W-1:0] sreg;
  logic [PH_W-1:0]  ph_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             active;

  // Low phase then high phase per bit; data advances as clk_o falls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sreg      <= '0;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
      active    <= 1'b0;
      clk_o     <= 1'b0;
      data_o    <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (load) begin
        sreg    <= word;
        data_o  <= word[REG_W-1];
        clk_o   <= 1'b0;
        ph_cnt  <= '0;
        bit_cnt <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (ph_cnt == PH_W'(2 * CLK_DIV - 1)) begin
          clk_o  <= 1'b0;
          ph_cnt <= '0;
          if (bit_cnt == BIT_W'(REG_W - 1)) begin
            active <= 1'b0;
            data_o <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            sreg    <= {sreg[REG_W-2:0], 1'b0};
            data_o  <= sreg[REG_W-2];
          end
        end else begin
          ph_cnt <= ph_cnt + PH_W'(1);
          if (ph_cnt == PH_W'(CLK_DIV - 1)) clk_o <= 1'b1;
          if (ph_cnt == PH_W'(2 * CLK_DIV - 2) && bit_cnt == BIT_W'(REG_W - 1)) word_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adf4158_prog.sv
// ADF4158 programming engine: host-writable register bank serialised R(N-1)..R0
// over CLK/DATA/LE, with CE power-up delay and TXDATA gating until configured.
module adf4158_prog
  import adf4158_pkg::*;
#(
  parameter int unsigned NREG     = ADF4158_NREG,
  parameter int unsigned REG_W    = ADF4158_REG_W,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned LE_W     = 4,
  parameter int unsigned CE_DELAY = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  adf4158_prog_if.slave host,
  output logic          ce_o,
  output logic          le_o,
  output logic          clk_o,
  output logic          data_o,
  output logic          txdata_o
);

  localparam int unsigned AW      = clog2_min1(NREG);
  localparam int unsigned CNT_MAX = (CE_DELAY > LE_W) ? CE_DELAY : LE_W;
  localparam int unsigned CNT_W   = clog2_min1(CNT_MAX);

  state_e           state;
  logic [AW-1:0]    idx;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] bank [NREG];

  logic             addr_ok_c;
  logic             wr_c;
  logic             load_c;
  logic [REG_W-1:0] word_c;
  logic             word_done;

  // Out-of-range addresses only exist when NREG is not a power of two.
  generate
    if (NREG == (1 << AW)) begin : g_addr_full
      assign addr_ok_c = 1'b1;
    end else begin : g_addr_part
      assign addr_ok_c = (32'(host.cfg_addr_i) < NREG);
    end
  endgenerate

  assign wr_c   = host.cfg_we_i & ~host.busy_o & addr_ok_c;
  assign load_c = (state == LOAD);
  assign word_c = bank[idx];

  // Register bank; frozen while a pass is running.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
    end else if (wr_c) begin
      bank[host.cfg_addr_i] <= host.cfg_data_i;
    end
  end

  // Pass sequencer with registered CE/LE/status and TXDATA gating.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      idx               <= '0;
      cnt               <= '0;
      host.busy_o       <= 1'b0;
      host.done_o       <= 1'b0;
      host.configured_o <= 1'b0;
      ce_o              <= 1'b0;
      le_o              <= 1'b1;
      txdata_o          <= 1'b0;
    end else begin
      host.done_o <= 1'b0;
      txdata_o    <= host.ramp_i & host.configured_o & ~host.busy_o;
      case (state)
        IDLE: begin
          if (host.start_i) begin
            host.busy_o <= 1'b1;
            idx         <= AW'(NREG - 1);
            cnt         <= '0;
            if (!ce_o) begin
              ce_o  <= 1'b1;
              state <= PWRUP;
            end else begin
              le_o  <= 1'b0;
              state <= LOAD;
            end
          end
        end
        PWRUP: begin
          if (cnt == CNT_W'(CE_DELAY - 1)) begin
            le_o  <= 1'b0;
            state <= LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (word_done) begin
            le_o  <= 1'b1;
            cnt   <= '0;
            state <= LATCH;
          end
        end
        LATCH: begin
          if (cnt == CNT_W'(LE_W - 1)) begin
            if (idx != '0) begin
              idx   <= idx - AW'(1);
              le_o  <= 1'b0;
              state <= LOAD;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          host.done_o       <= 1'b1;
          host.busy_o       <= 1'b0;
          host.configured_o <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  adf4158_ser #(
    .REG_W   (REG_W),
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load      (load_c),
    .word      (word_c),
    .clk_o     (clk_o),
    .data_o    (data_o),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_adf4158_prog.sv
// Self-checking bench for adf4158_prog against a pass-level reference model.
module tb_adf4158_prog;

  localparam int NREG     = 8;
  localparam int REG_W    = 32;
  localparam int CLK_DIV  = 2;
  localparam int LE_W     = 4;
  localparam int CE_DELAY = 16;
  localparam int REG_T    = 1 + 2 * CLK_DIV * REG_W + LE_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_ce, pll_le, pll_clk, pll_data, pll_tx;

  int errors = 0;
  int checks = 0;

  logic [31:0] bank_m [NREG];
  bit          configured_m = 1'b0;
  logic [31:0] cap_q [$];
  logic [31:0] cap_cur = '0;
  int          cap_bits = 0;

  adf4158_prog_if #(.NREG(NREG), .REG_W(REG_W)) hif ();

  adf4158_prog #(
    .NREG(NREG), .REG_W(REG_W), .CLK_DIV(CLK_DIV), .LE_W(LE_W), .CE_DELAY(CE_DELAY)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .host     (hif),
    .ce_o     (pll_ce),
    .le_o     (pll_le),
    .clk_o    (pll_clk),
    .data_o   (pll_data),
    .txdata_o (pll_tx)
  );

  always #5 clk = ~clk;

  // Behaves like the PLL input shifter: one bit per CLK rising edge.
  always @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_bits = 0;
    end else begin
      cap_cur = {cap_cur[30:0], pll_data};
      cap_bits++;
      if (cap_bits == REG_W) begin
        cap_q.push_back(cap_cur);
        cap_bits = 0;
      end
    end
  end

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    hif.cfg_we_i   = 1'b1;
    hif.cfg_addr_i = a;
    hif.cfg_data_i = d;
    @(negedge clk);
    hif.cfg_we_i = 1'b0;
    bank_m[a] = d;
  endtask

  // Runs one complete pass and checks timing, pins and shifted words.
  task automatic run_pass(input int pwr, input bit poke, input bit wr_start,
                          input logic [2:0] wa, input logic [31:0] wd);
    int exp_len, exp_rise, done_n, rise_n, runs, bad_runs, run_len, ce_bad, tx_bad, busy_bad;
    logic prev_clk, prev_le;
    exp_len  = pwr + NREG * REG_T + 1;
    exp_rise = pwr + 1 + CLK_DIV;
    cap_q.delete();
    @(negedge clk);
    hif.start_i = 1'b1;
    if (wr_start) begin
      hif.cfg_we_i   = 1'b1;
      hif.cfg_addr_i = wa;
      hif.cfg_data_i = wd;
      bank_m[wa] = wd;
    end
    done_n = -1; rise_n = -1; runs = 0; bad_runs = 0; run_len = 0;
    ce_bad = 0; tx_bad = 0; busy_bad = 0;
    prev_clk = pll_clk;
    prev_le  = pll_le;
    for (int n = 0; n < exp_len + 50; n++) begin
      @(negedge clk);
      hif.start_i  = 1'b0;
      hif.cfg_we_i = 1'b0;
      hif.ramp_i   = 1'($urandom);
      if (poke && n == 50) begin
        hif.cfg_we_i   = 1'b1;
        hif.cfg_addr_i = 3'd3;
        hif.cfg_data_i = 32'hDEAD_BEEF;
        hif.start_i    = 1'b1;
      end
      if (pll_ce !== 1'b1) ce_bad++;
      if (pll_tx !== 1'b0) tx_bad++;
      if (rise_n < 0 && pll_clk === 1'b1 && prev_clk === 1'b0) rise_n = n;
      if (pll_le === 1'b1) begin
        if (prev_le === 1'b0) begin
          runs++;
          run_len = 0;
        end
        run_len++;
      end else if (prev_le === 1'b1 && runs > 0) begin
        if (run_len != LE_W) bad_runs++;
      end
      prev_clk = pll_clk;
      prev_le  = pll_le;
      if (hif.done_o === 1'b1) begin
        done_n = n;
        break;
      end
      if (hif.busy_o !== 1'b1) busy_bad++;
    end
    hif.ramp_i   = 1'b0;
    hif.start_i  = 1'b0;
    hif.cfg_we_i = 1'b0;
    configured_m = 1'b1;

    checks++; if (done_n != exp_len) begin errors++; $display("FAIL pass_len: got %0d want %0d", done_n, exp_len); end
    checks++; if (rise_n != exp_rise) begin errors++; $display("FAIL first_clk_rise: got %0d want %0d", rise_n, exp_rise); end
    checks++; if (runs != NREG) begin errors++; $display("FAIL le_pulses: got %0d want %0d", runs, NREG); end
    checks++; if (bad_runs != 0) begin errors++; $display("FAIL le_width: got %0d bad pulses want 0", bad_runs); end
    checks++; if (ce_bad != 0) begin errors++; $display("FAIL ce_high: got %0d low samples want 0", ce_bad); end
    checks++; if (tx_bad != 0) begin errors++; $display("FAIL txdata_in_pass: got %0d high samples want 0", tx_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL busy_in_pass: got %0d idle samples want 0", busy_bad); end
    checks++; if (hif.configured_o !== 1'b1) begin errors++; $display("FAIL configured: got %b want 1", hif.configured_o); end
    checks++; if (pll_le !== 1'b1) begin errors++; $display("FAIL le_at_done: got %b want 1", pll_le); end
    checks++; if (cap_q.size() != NREG) begin errors++; $display("FAIL word_count: got %0d want %0d", cap_q.size(), NREG); end
    for (int i = 0; i < NREG && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== bank_m[NREG-1-i]) begin
        errors++;
        $display("FAIL word_R%0d: got %h want %h", NREG - 1 - i, cap_q[i], bank_m[NREG-1-i]);
      end
    end
  endtask

  task automatic test_reset();
    hif.cfg_we_i = 1'b0; hif.cfg_addr_i = '0; hif.cfg_data_i = '0;
    hif.start_i = 1'b0; hif.ramp_i = 1'b0;
    for (int i = 0; i < NREG; i++) bank_m[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hif.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", hif.busy_o); end
    checks++; if (hif.done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", hif.done_o); end
    checks++; if (hif.configured_o !== 1'b0) begin errors++; $display("FAIL rst_configured: got %b want 0", hif.configured_o); end
    checks++; if (pll_ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", pll_ce); end
    checks++; if (pll_le !== 1'b1) begin errors++; $display("FAIL rst_le: got %b want 1", pll_le); end
    checks++; if (pll_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b want 0", pll_clk); end
    checks++; if (pll_data !== 1'b0) begin errors++; $display("FAIL rst_data: got %b want 0", pll_data); end
    checks++; if (pll_tx !== 1'b0) begin errors++; $display("FAIL rst_tx: got %b want 0", pll_tx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (hif.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", hif.busy_o); end
  endtask

  task automatic test_txdata_pre();
    hif.ramp_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (pll_tx !== 1'b0) begin errors++; $display("FAIL tx_before_config: got %b want 0", pll_tx); end
    end
    hif.ramp_i = 1'b0;
  endtask

  task automatic test_first_pass();
    for (int k = 0; k < NREG; k++) write_reg(3'(k), 32'(k));
    run_pass(CE_DELAY, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_txdata_post();
    logic prev, r, exp;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp = prev & configured_m;
      checks++; if (pll_tx !== exp) begin errors++; $display("FAIL tx_follow: got %b want %b", pll_tx, exp); end
      r = 1'($urandom);
      hif.ramp_i = r;
      prev = r;
    end
    hif.ramp_i = 1'b0;
  endtask

  task automatic test_second_pass();
    for (int k = 0; k < NREG; k++) write_reg(3'(k), $urandom);
    run_pass(0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_busy_write();
    run_pass(0, 1'b1, 1'b0, 3'd0, 32'd0);
    run_pass(0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_same_cycle();
    run_pass(0, 1'b0, 1'b1, 3'd0, 32'h0000_0007);
    checks++;
    if (cap_q.size() != NREG || cap_q[NREG-1] !== 32'h0000_0007) begin
      errors++;
      $display("FAIL last_word: got %h want %h", (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 32'hx, 32'h0000_0007);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hif.start_i = 1'b1;
    @(negedge clk);
    hif.start_i = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (pll_le !== 1'b0) begin errors++; $display("FAIL mid_shift_le: got %b want 0", pll_le); end
    rst_n = 1'b0;
    #1;
    checks++; if (hif.busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", hif.busy_o); end
    checks++; if (hif.configured_o !== 1'b0) begin errors++; $display("FAIL arst_configured: got %b want 0", hif.configured_o); end
    checks++; if (pll_ce !== 1'b0) begin errors++; $display("FAIL arst_ce: got %b want 0", pll_ce); end
    checks++; if (pll_le !== 1'b1) begin errors++; $display("FAIL arst_le: got %b want 1", pll_le); end
    checks++; if (pll_clk !== 1'b0) begin errors++; $display("FAIL arst_clk: got %b want 0", pll_clk); end
    checks++; if (pll_data !== 1'b0) begin errors++; $display("FAIL arst_data: got %b want 0", pll_data); end
    for (int i = 0; i < NREG; i++) bank_m[i] = '0;
    configured_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(CE_DELAY, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_txdata_pre();
    test_first_pass();
    test_txdata_post();
    test_second_pass();
    test_busy_write();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
